// File: rtl/buffer5_ctrl.sv
// buffer5_ctrl: frame controller for a 5-line buffer feeding a 5x5 window grid.
// Optional macro WINDOW_BORDER_EN adds a zero-padded flush phase, full-frame windows and oBorder.
module buffer5_ctrl #(
  parameter int unsigned p_width      = 640,
  parameter int unsigned p_height     = 480,
  parameter int unsigned p_coord_bits = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iSof,
  input  logic                    iValid,
  output logic                    oReady,
  output logic                    oClken,
  output logic                    oPad,
  output logic                    oRamClr,
  output logic                    oWinValid,
  output logic [p_coord_bits-1:0] oCenterX,
  output logic [p_coord_bits-1:0] oCenterY,
`ifdef WINDOW_BORDER_EN
  output logic                    oBorder,
`endif
  output logic                    oFrameDone,
  output logic                    oOverrun
);

  localparam int unsigned lp_col_bits = $clog2(p_width);
  // Row counter keeps running through the flush phase, up to p_height+2.
  localparam int unsigned lp_row_bits = $clog2(p_height + 3);

  localparam logic [lp_col_bits-1:0] lp_col_last = lp_col_bits'(p_width - 1);
  localparam logic [lp_row_bits-1:0] lp_row_last = lp_row_bits'(p_height - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
`ifdef WINDOW_BORDER_EN
    S_FLUSH,
`endif
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [lp_col_bits-1:0]  r_col;
  logic [lp_row_bits-1:0]  r_row;
  logic                    r_ram_clr;
  logic                    r_win_valid;
  logic [p_coord_bits-1:0] r_cx;
  logic [p_coord_bits-1:0] r_cy;
  logic                    r_frame_done;
  logic                    r_overrun;
  logic                    w_last_px;
  logic                    w_emit;
  logic                    w_ovr_set;

`ifdef WINDOW_BORDER_EN
  logic [lp_col_bits-1:0]  r_ptr_x;
  logic [lp_row_bits-1:0]  r_ptr_y;
  logic                    r_border;
  logic                    w_last_win;
  logic                    w_border;

  // Next window centre to emit, tracked independently of the input counters.
  assign w_last_win = (r_ptr_x == lp_col_last) && (r_ptr_y == lp_row_last);
  assign w_border   = (r_ptr_x < lp_col_bits'(2)) ||
                      (r_ptr_x > lp_col_bits'(p_width - 3)) ||
                      (r_ptr_y < lp_row_bits'(2)) ||
                      (r_ptr_y > lp_row_bits'(p_height - 3));
  // The grid is full once 2*p_width+2 shifts have happened (row 2, col 2).
  assign w_emit     = oClken &&
                      ((r_row > lp_row_bits'(2)) ||
                       ((r_row == lp_row_bits'(2)) && (r_col >= lp_col_bits'(2))));
`else
  assign w_emit     = oClken && (r_row >= lp_row_bits'(4)) && (r_col >= lp_col_bits'(4));
`endif

  assign w_last_px = (r_col == lp_col_last) && (r_row == lp_row_last);
  assign w_ovr_set = iValid && !oReady && (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and combinational line-buffer controls
  always_comb begin
    w_next = r_state;
    oReady = 1'b0;
    oClken = 1'b0;
    oPad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iSof) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_next = S_RUN;
      end
      S_RUN: begin
        oReady = 1'b1;
        oClken = iValid;
        if (iValid && w_last_px) begin
`ifdef WINDOW_BORDER_EN
          w_next = S_FLUSH;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef WINDOW_BORDER_EN
      S_FLUSH: begin
        oPad   = 1'b1;
        oClken = 1'b1;
        if (w_last_win) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Start-of-frame restarts from any state.
    if (iSof) w_next = S_CLEAR;
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_clr    <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_ram_clr    <= (w_next == S_CLEAR);
      r_frame_done <= (w_next == S_DONE);
      if (iSof) begin
        r_overrun <= 1'b0;
      end else if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Input raster counters, advancing on every line-buffer shift
  always_ff @(posedge clk) begin
    if (reset || iSof) begin
      r_col <= '0;
      r_row <= '0;
    end else if (oClken) begin
      if (r_col == lp_col_last) begin
        r_col <= '0;
        r_row <= r_row + lp_row_bits'(1);
      end else begin
        r_col <= r_col + lp_col_bits'(1);
      end
    end
  end

  // Window outputs, registered on the same edge the grid shifts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_valid <= 1'b0;
      r_cx        <= '0;
      r_cy        <= '0;
`ifdef WINDOW_BORDER_EN
      r_border    <= 1'b0;
      r_ptr_x     <= '0;
      r_ptr_y     <= '0;
`endif
    end else if (iSof) begin
      r_win_valid <= 1'b0;
`ifdef WINDOW_BORDER_EN
      r_ptr_x     <= '0;
      r_ptr_y     <= '0;
`endif
    end else if (w_emit) begin
      r_win_valid <= 1'b1;
`ifdef WINDOW_BORDER_EN
      r_cx        <= p_coord_bits'(r_ptr_x);
      r_cy        <= p_coord_bits'(r_ptr_y);
      r_border    <= w_border;
      if (r_ptr_x == lp_col_last) begin
        r_ptr_x <= '0;
        r_ptr_y <= r_ptr_y + lp_row_bits'(1);
      end else begin
        r_ptr_x <= r_ptr_x + lp_col_bits'(1);
      end
`else
      r_cx        <= p_coord_bits'(r_col) - p_coord_bits'(2);
      r_cy        <= p_coord_bits'(r_row) - p_coord_bits'(2);
`endif
    end else begin
      r_win_valid <= 1'b0;
    end
  end

  assign oRamClr    = r_ram_clr;
  assign oWinValid  = r_win_valid;
  assign oCenterX   = r_cx;
  assign oCenterY   = r_cy;
  assign oFrameDone = r_frame_done;
  assign oOverrun   = r_overrun;
`ifdef WINDOW_BORDER_EN
  assign oBorder    = r_border;
`endif

endmodule

// File: tb/tb_buffer5_ctrl.sv
// tb_buffer5_ctrl: scoreboard bench for buffer5_ctrl at 8x6; expected windows queued at stimulus time.
// Handles both the default build and WINDOW_BORDER_EN.
module tb_buffer5_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CB = 10;
`ifdef WINDOW_BORDER_EN
  localparam int EXP_WIN    = 48;
  localparam int EXP_FLUSH  = 18;
  localparam int EXP_BORDER = 40;
`else
  localparam int EXP_WIN    = 8;
  localparam int EXP_FLUSH  = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          iSof;
  logic          iValid;
  logic          oReady;
  logic          oClken;
  logic          oPad;
  logic          oRamClr;
  logic          oWinValid;
  logic [CB-1:0] oCenterX;
  logic [CB-1:0] oCenterY;
`ifdef WINDOW_BORDER_EN
  logic          oBorder;
`endif
  logic          oFrameDone;
  logic          oOverrun;

  buffer5_ctrl #(.p_width(W), .p_height(H), .p_coord_bits(CB)) dut (
    .clk        (clk),
    .reset      (reset),
    .iSof       (iSof),
    .iValid     (iValid),
    .oReady     (oReady),
    .oClken     (oClken),
    .oPad       (oPad),
    .oRamClr    (oRamClr),
    .oWinValid  (oWinValid),
    .oCenterX   (oCenterX),
    .oCenterY   (oCenterY),
`ifdef WINDOW_BORDER_EN
    .oBorder    (oBorder),
`endif
    .oFrameDone (oFrameDone),
    .oOverrun   (oOverrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int b;
  } win_t;

  win_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_win    = 0;
  int   n_border = 0;
  int   n_fd     = 0;
  int   win_base = 0;
  int   border_base = 0;
  int   fd_base  = 0;
  logic prev_clken = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue expected centres for linear centre indices first..last.
  task automatic push_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      win_t e;
      e.x = i % W;
      e.y = i / W;
      e.b = (e.x < 2 || e.x > W - 3 || e.y < 2 || e.y > H - 3) ? 1 : 0;
`ifdef WINDOW_BORDER_EN
      exp_q.push_back(e);
`else
      if (e.b == 0) exp_q.push_back(e);
`endif
    end
  endtask

  task automatic new_frame();
    win_base    = n_win;
    border_base = n_border;
    push_range(0, W * H - 1);
  endtask

  // Monitor: pops one expectation per presented window.
  always @(negedge clk) begin
    if (oWinValid) begin
      n_win++;
`ifdef WINDOW_BORDER_EN
      if (oBorder) n_border++;
`endif
      if (exp_q.size() == 0) begin
        check("win_unexpected", int'(oWinValid), 0);
      end else begin
        win_t e;
        e = exp_q.pop_front();
        check("win_cx", int'(oCenterX), e.x);
        check("win_cy", int'(oCenterY), e.y);
`ifdef WINDOW_BORDER_EN
        check("win_border", int'(oBorder), e.b);
`endif
      end
    end
    if (!prev_clken && oWinValid) check("win_in_gap", int'(oWinValid), 0);
    if (oFrameDone) n_fd++;
    prev_clken = oClken;
  end

  // Tasks are entered and left at posedge+1.
  task automatic start_frame(input logic clear_valid);
    iSof   = 1'b1;
    iValid = 1'b0;
    @(posedge clk); #1;
    iSof   = 1'b0;
    iValid = clear_valid;
    @(negedge clk);
    check("clear_ramclr", int'(oRamClr), 1);
    check("clear_ready", int'(oReady), 0);
    check("clear_clken", int'(oClken), 0);
    check("clear_overrun", int'(oOverrun), 0);
    @(posedge clk); #1;
    iValid = 1'b0;
    @(negedge clk);
    check("run_ramclr", int'(oRamClr), 0);
    check("run_ready", int'(oReady), 1);
    check("run_overrun", int'(oOverrun), int'(clear_valid));
    @(posedge clk); #1;
  endtask

  task automatic feed(input int n, input bit toggle);
    int sent  = 0;
    int guard = 0;
    bit ph    = 1'b1;
    while (sent < n && guard < 4 * n + 10) begin
      iValid = toggle ? ph : 1'b1;
      @(posedge clk);
      if (iValid) sent++;
      #1;
      ph = !ph;
      guard++;
    end
    iValid = 1'b0;
    check("feed_count", sent, n);
  endtask

  task automatic finish_frame(input logic ovr_drive, input int ovr_exp);
    bit seen  = 1'b0;
    int n_pad = 0;
    iValid = ovr_drive;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (oFrameDone) seen = 1'b1;
      else if (oPad && oClken) n_pad++;
    end
    check("frame_done_seen", int'(seen), 1);
    check("flush_cycles", n_pad, EXP_FLUSH);
    @(posedge clk); #1;
    iValid = 1'b0;
    @(negedge clk);
    check("frame_done_len", int'(oFrameDone), 0);
    check("idle_ready", int'(oReady), 0);
    check("frame_overrun", int'(oOverrun), ovr_exp);
    check("frame_windows", n_win - win_base, EXP_WIN);
    check("frame_queue_left", exp_q.size(), 0);
`ifdef WINDOW_BORDER_EN
    check("frame_borders", n_border - border_base, EXP_BORDER);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    iSof   = 1'b0;
    iValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(oReady), 0);
    check("rst_clken", int'(oClken), 0);
    check("rst_pad", int'(oPad), 0);
    check("rst_ramclr", int'(oRamClr), 0);
    check("rst_winvalid", int'(oWinValid), 0);
    check("rst_cx", int'(oCenterX), 0);
    check("rst_cy", int'(oCenterY), 0);
    check("rst_framedone", int'(oFrameDone), 0);
    check("rst_overrun", int'(oOverrun), 0);
`ifdef WINDOW_BORDER_EN
    check("rst_border", int'(oBorder), 0);
`endif

    // iValid in IDLE: ignored, no overrun
    @(posedge clk); #1;
    iValid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_clken", int'(oClken), 0);
      check("idle_overrun", int'(oOverrun), 0);
    end
    @(posedge clk); #1;
    iValid = 1'b0;

    // Back-to-back frame
    start_frame(1'b0);
    new_frame();
    feed(W * H, 1'b0);
    finish_frame(1'b0, 0);

    // Alternating valid/gap frame
    start_frame(1'b0);
    new_frame();
    feed(W * H, 1'b1);
    finish_frame(1'b0, 0);

    // iValid during CLEAR: overrun, pixel not counted
    start_frame(1'b1);
    new_frame();
    feed(W * H, 1'b0);
    finish_frame(1'b0, 1);

    // Restart at pixel 20, then iValid during flush/done
    start_frame(1'b0);
`ifdef WINDOW_BORDER_EN
    push_range(0, 1);
`endif
    feed(20, 1'b0);
    fd_base = n_fd;
    start_frame(1'b0);
    check("restart_no_done", n_fd, fd_base);
    new_frame();
    feed(W * H, 1'b0);
    finish_frame(1'b1, 1);

    // Reset mid-RUN
    start_frame(1'b0);
    feed(15, 1'b0);
    fd_base = n_fd;
    reset  = 1'b1;
    iValid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_ready", int'(oReady), 0);
    check("mid_rst_clken", int'(oClken), 0);
    check("mid_rst_pad", int'(oPad), 0);
    check("mid_rst_winvalid", int'(oWinValid), 0);
    check("mid_rst_cx", int'(oCenterX), 0);
    check("mid_rst_overrun", int'(oOverrun), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_clken", int'(oClken), 0);
      check("post_rst_ready", int'(oReady), 0);
      check("post_rst_overrun", int'(oOverrun), 0);
    end
    check("mid_rst_no_done", n_fd, fd_base);
    check("mid_rst_queue", exp_q.size(), 0);
    @(posedge clk); #1;
    iValid = 1'b0;

    // Clean frame after the abandoned one
    start_frame(1'b0);
    new_frame();
    feed(W * H, 1'b0);
    finish_frame(1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
